// File: rtl/taylor_poly_seq_if.sv
// Request, result and coefficient-configuration signals of taylor_poly_seq (DUT side is the slave).
interface taylor_poly_seq_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ORDER      = 4,
    parameter int NUM_CH     = 4
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = $clog2(ORDER + 2);

    logic                  in_valid;
    logic                  in_ready;
    logic [CH_W-1:0]       in_ch;
    logic [DATA_WIDTH-1:0] x_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] y_out;
    logic [CH_W-1:0]       out_ch;
    logic                  out_ovf;
    logic                  cfg_we;
    logic [CH_W-1:0]       cfg_ch;
    logic [ADDR_W-1:0]     cfg_addr;
    logic [DATA_WIDTH-1:0] cfg_wdata;
    logic                  cfg_err;

    modport master (
        output in_valid, in_ch, x_in, out_ready, cfg_we, cfg_ch, cfg_addr, cfg_wdata,
        input  in_ready, out_valid, y_out, out_ch, out_ovf, cfg_err
    );

    modport slave (
        input  in_valid, in_ch, x_in, out_ready, cfg_we, cfg_ch, cfg_addr, cfg_wdata,
        output in_ready, out_valid, y_out, out_ch, out_ovf, cfg_err
    );
endinterface

// File: rtl/taylor_poly_seq.sv
// Per-channel programmable Horner evaluator on one shared multiplier; TAYLOR_POLY_SEQ_SAT_EN selects saturation.
// Latency ORDER+1 cycles, II ORDER+3; one request in flight, result held in DONE until out_ready.
module taylor_poly_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int ORDER      = 4,
    parameter int NUM_CH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    taylor_poly_seq_if.slave bus
);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int ADDR_W = $clog2(ORDER + 2);
    localparam int PW     = 2 * DATA_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SUB  = 2'd1;
    localparam logic [1:0] LOOP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [ADDR_W-1:0] K_START = ADDR_W'(ORDER - 1);

    logic [1:0]                   state;
    logic signed [DATA_WIDTH-1:0] x_lat, d, acc;
    logic [CH_W-1:0]              ch_lat;
    logic [ADDR_W-1:0]            k;
    logic                         ovf;
    logic                         cfg_err_q;
    logic signed [DATA_WIDTH-1:0] coef [NUM_CH][ORDER+2];

    logic signed [DATA_WIDTH-1:0] c_k, x0, d_next, step_next;
    logic signed [PW-1:0]         prod;
    logic                         diff_ovf, step_ovf;

    assign c_k  = coef[ch_lat][k];
    assign x0   = coef[ch_lat][ORDER+1];
    assign prod = PW'(acc) * PW'(d);

`ifdef TAYLOR_POLY_SEQ_SAT_EN
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [PW-1:0]         prod_sh;
    logic signed [DATA_WIDTH-1:0] mul_sat;
    logic [DATA_WIDTH:0]          sum_full, diff_full;
    logic                         mul_ovf, add_ovf;

    // Each operation clamps on its own, so a saturated product can still be pulled back by c_k.
    always_comb begin
        prod_sh   = prod >>> FRAC_BITS;
        mul_ovf   = (prod_sh[PW-1:DATA_WIDTH-1] != {(PW-DATA_WIDTH+1){prod_sh[PW-1]}});
        mul_sat   = mul_ovf ? (prod_sh[PW-1] ? SAT_MIN : SAT_MAX) : prod_sh[DATA_WIDTH-1:0];
        sum_full  = {mul_sat[DATA_WIDTH-1], mul_sat} + {c_k[DATA_WIDTH-1], c_k};
        add_ovf   = (sum_full[DATA_WIDTH] != sum_full[DATA_WIDTH-1]);
        step_next = add_ovf ? (sum_full[DATA_WIDTH] ? SAT_MIN : SAT_MAX) : sum_full[DATA_WIDTH-1:0];
        step_ovf  = mul_ovf | add_ovf;
        diff_full = {x_lat[DATA_WIDTH-1], x_lat} - {x0[DATA_WIDTH-1], x0};
        diff_ovf  = (diff_full[DATA_WIDTH] != diff_full[DATA_WIDTH-1]);
        d_next    = diff_ovf ? (diff_full[DATA_WIDTH] ? SAT_MIN : SAT_MAX) : diff_full[DATA_WIDTH-1:0];
    end
`else
    always_comb begin
        step_next = DATA_WIDTH'(prod >>> FRAC_BITS) + c_k;
        d_next    = x_lat - x0;
        step_ovf  = 1'b0;
        diff_ovf  = 1'b0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            x_lat  <= '0;
            ch_lat <= '0;
            d      <= '0;
            acc    <= '0;
            k      <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    x_lat  <= bus.x_in;
                    ch_lat <= bus.in_ch;
                    ovf    <= 1'b0;
                    state  <= SUB;
                end
                SUB: begin
                    d     <= d_next;
                    acc   <= coef[ch_lat][ORDER];
                    k     <= K_START;
                    ovf   <= ovf | diff_ovf;
                    state <= LOOP;
                end
                LOOP: begin
                    acc <= step_next;
                    ovf <= ovf | step_ovf;
                    if (k == '0) state <= DONE;
                    else         k     <= k - ADDR_W'(1);
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The in-flight channel is locked only while its coefficients are being read (SUB/LOOP).
    logic [31:0] cfg_ch_ext, cfg_addr_ext;
    logic        busy, cfg_bad;

    assign cfg_ch_ext   = 32'(bus.cfg_ch);
    assign cfg_addr_ext = 32'(bus.cfg_addr);
    assign busy         = (state == SUB) || (state == LOOP);
    assign cfg_bad      = (cfg_addr_ext > 32'(ORDER + 1)) || (cfg_ch_ext >= 32'(NUM_CH)) ||
                          (busy && (bus.cfg_ch == ch_lat));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                for (int a = 0; a < ORDER + 2; a++)
                    coef[c][a] <= '0;
        end else begin
            cfg_err_q <= bus.cfg_we && cfg_bad;
            if (bus.cfg_we && !cfg_bad)
                coef[bus.cfg_ch][bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.y_out     = acc;
    assign bus.out_ch    = ch_lat;
    assign bus.out_ovf   = ovf;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: doc/taylor_poly_seq.md
# taylor_poly_seq

Multi-channel, runtime-programmable Taylor polynomial evaluator. It uses one shared multiplier and iterates Horner's rule over ORDER+1 coefficients, stored per channel and loaded through a configuration port. It is the successor to the fully pipelined fixed-coefficient evaluator and trades throughput for area and field reprogrammability. Inputs and outputs use ready/valid handshakes; the block sits between a sample source and any downstream datapath that consumes signed fixed-point results.

## Interface
- DATA_WIDTH, 32, width of x, coefficients, x0 and y; signed Q(DATA_WIDTH-FRAC_BITS-1).FRAC_BITS
- FRAC_BITS, 16, fractional bits
- ORDER, 4, polynomial order N (≥1); N+1 coefficients per channel
- NUM_CH, 4, number of independent coefficient banks (≥1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_ch  in  $clog2(NUM_CH) (min 1)  channel select for request
- x_in  in  DATA_WIDTH  signed evaluation point
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- y_out  out  DATA_WIDTH  signed result P(x)
- out_ch  out  $clog2(NUM_CH)  channel of result
- out_ovf  out  1  overflow occurred during this evaluation
- cfg_we  in  1  coefficient write strobe
- cfg_ch  in  $clog2(NUM_CH)  target channel
- cfg_addr  in  $clog2(ORDER+2)  0..ORDER = c_k, ORDER+1 = x0
- cfg_wdata  in  DATA_WIDTH  write data
- cfg_err  out  1  one-cycle pulse: write rejected

## Operation
- Storage: NUM_CH × (ORDER+2) registers; all reset to 0.
- Arithmetic: d = x − x0 (DATA_WIDTH, signed). Horner: acc = c_N, then for k = N−1 down to 0: acc = ((acc·d) >>> FRAC_BITS) + c_k. Product is 2·DATA_WIDTH bits; shift is arithmetic (truncation toward −∞); the low DATA_WIDTH bits are kept, subject to Configuration.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch x_in and in_ch; go to SUB.
  - SUB: compute d; acc←c_N; k←N−1; go to LOOP.
  - LOOP: one Horner step per cycle. After the step with k=0, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is high only in IDLE. out_valid is high only in DONE. y_out, out_ch and out_ovf are stable while out_valid && !out_ready.
- Config writes:
  - Accepted in any state.
  - Rejected with a cfg_err pulse in the following cycle, storage unchanged, if cfg_addr > ORDER+1 or cfg_ch ≥ NUM_CH.
  - Also rejected if cfg_ch equals the latched channel while state is SUB or LOOP.
  - A write to the in-flight channel in DONE is accepted. It does not affect the held result.
- Reset, asserted any time (including mid-evaluation): state→IDLE, in_ready=0 while rst is high, out_valid=0, y_out=0, out_ch=0, out_ovf=0, cfg_err=0, all coefficients and x0 = 0.

## Timing
- Request accepted at edge E: out_valid rises after edge E+N+1, so latency is N+1 cycles.
- out_ready held high: DONE lasts 1 cycle, IDLE 1 cycle, so the minimum initiation interval is N+3 cycles.
- A config write at edge E is visible to a request accepted at edge E+1 or later. cfg_err pulses in cycle E+1.

## Configuration
- TAYLOR_POLY_SEQ_SAT_EN defined:
  - Every product-shift and every addition whose true value is outside the signed DATA_WIDTH range clamps to 0x7FF…F or 0x800…0.
  - Any clamp sets out_ovf for that evaluation; it clears when the next request is accepted.
- Undefined:
  - Two's-complement wrap.
  - out_ovf tied 0.

## Test plan
- Program ch0 c2=1.0 (0x00010000), other coefficients and x0 = 0 (ORDER=4); x_in=3.0 → y_out=0x00090000 after 5 cycles; x_in=−2.0 → 0x00040000.
- Program ch1 with e^x: c0=c1=0x10000, c2=0x8000, c3=0x2AAB, c4=0x0AAB; x_in=1.0 → 0x0002B556; x_in=0 → 0x00010000.
- Program ch2 x0=1.0, c1=1.0, others 0; x_in=0.5 → 0xFFFF8000.
- Hold out_ready=0 for 5 cycles after out_valid → y_out, out_ch stable; in_ready=0 throughout; back-to-back requests with out_ready=1 are accepted every 7 cycles.
- ch0 x² with x_in=200.0:
  - with SAT_EN → y_out=0x7FFFFFFF, out_ovf=1;
  - without → wrapped low 32 bits, out_ovf=0.
- Write to ch0 c2 during LOOP of a ch0 evaluation → cfg_err pulses, result unchanged. cfg_addr=7 → cfg_err. Assert rst mid-LOOP → out_valid=0 and the coefficients read back as 0 (ch0 x=3.0 gives 0).
